// File: rtl/video_frame_mux.sv
// video_frame_mux: frame-aligned 2:1 AXI4-Stream video selector.
// The pixel path is combinational; only control state is registered.
module video_frame_mux #(
   parameter int DATAW = 24,
   parameter int LINES = 1080,
   parameter int LCNTW = 12,
   parameter int FCNTW = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sel,
   input  logic [DATAW-1:0] s0_axis_tdata,
   input  logic             s0_axis_tvalid,
   output logic             s0_axis_tready,
   input  logic             s0_axis_tuser,
   input  logic             s0_axis_tlast,
   input  logic [DATAW-1:0] s1_axis_tdata,
   input  logic             s1_axis_tvalid,
   output logic             s1_axis_tready,
   input  logic             s1_axis_tuser,
   input  logic             s1_axis_tlast,
   output logic [DATAW-1:0] m_axis_tdata,
   output logic             m_axis_tvalid,
   input  logic             m_axis_tready,
   output logic             m_axis_tuser,
   output logic             m_axis_tlast,
   output logic             active_sel,
   output logic             busy,
   output logic             frame_done,
   output logic [FCNTW-1:0] frame_cnt,
   output logic             err_sof,
   output logic             err_nosof
);

   typedef enum logic [1:0] {IDLE, SYNC, PASS} state_t;

   localparam logic [LCNTW-1:0] LAST = LCNTW'(LINES - 1);

   state_t           state;
   logic [LCNTW-1:0] line_cnt;
   logic [DATAW-1:0] s_tdata;
   logic             s_tvalid;
   logic             s_tuser;
   logic             s_tlast;
   logic             s_tready;
   logic             acc;
   logic             beat;
   logic             eof;
   logic [LCNTW-1:0] base;

   always_comb begin
      s_tdata  = active_sel ? s1_axis_tdata  : s0_axis_tdata;
      s_tvalid = active_sel ? s1_axis_tvalid : s0_axis_tvalid;
      s_tuser  = active_sel ? s1_axis_tuser  : s0_axis_tuser;
      s_tlast  = active_sel ? s1_axis_tlast  : s0_axis_tlast;
   end

   always_comb begin
      m_axis_tvalid = 1'b0;
      s_tready      = 1'b0;
      unique case (state)
         SYNC: begin
            m_axis_tvalid = s_tvalid & s_tuser;
            s_tready      = s_tuser ? m_axis_tready : 1'b1;
         end
         PASS: begin
            m_axis_tvalid = s_tvalid;
            s_tready      = m_axis_tready;
         end
         default: ;
      endcase
   end

   assign m_axis_tdata   = m_axis_tvalid ? s_tdata : '0;
   assign m_axis_tuser   = m_axis_tvalid & s_tuser;
   assign m_axis_tlast   = m_axis_tvalid & s_tlast;
   assign s0_axis_tready = s_tready & ~active_sel;
   assign s1_axis_tready = s_tready & active_sel;

   // beat = a handshake that is forwarded downstream
   assign acc  = s_tvalid & s_tready;
   assign beat = acc & ((state == PASS) | ((state == SYNC) & s_tuser));
   assign base = s_tuser ? '0 : line_cnt;
   assign eof  = s_tlast & (base == LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         active_sel <= 1'b0;
         busy       <= 1'b0;
         line_cnt   <= '0;
         frame_cnt  <= '0;
         frame_done <= 1'b0;
         err_sof    <= 1'b0;
         err_nosof  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         err_sof    <= 1'b0;
         err_nosof  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (en) begin
                  active_sel <= sel;
                  state      <= SYNC;
                  busy       <= 1'b1;
               end
            end
            SYNC: begin
               err_nosof <= acc & ~s_tuser;
               if (!en && !beat) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            PASS: err_sof <= acc & s_tuser;
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
         // a committed SOF beat wins over a late en drop in SYNC
         if (beat) begin
            if (eof) begin
               line_cnt   <= '0;
               frame_done <= 1'b1;
               frame_cnt  <= frame_cnt + FCNTW'(1);
               state      <= en ? SYNC : IDLE;
               busy       <= en;
               if (en) active_sel <= sel;
            end else begin
               line_cnt <= base + LCNTW'(s_tlast);
               state    <= PASS;
               busy     <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_video_frame_mux.sv
// tb_video_frame_mux: directed scoreboard bench for video_frame_mux.
// Sources are TPG models; expected beats are queued as stimulus is planned.
module tb_video_frame_mux;

   localparam int DATAW = 24;
   localparam int LINES = 4;
   localparam int LCNTW = 3;
   localparam int FCNTW = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             sel;
   logic [DATAW-1:0] s0_axis_tdata;
   logic             s0_axis_tvalid;
   logic             s0_axis_tready;
   logic             s0_axis_tuser;
   logic             s0_axis_tlast;
   logic [DATAW-1:0] s1_axis_tdata;
   logic             s1_axis_tvalid;
   logic             s1_axis_tready;
   logic             s1_axis_tuser;
   logic             s1_axis_tlast;
   logic [DATAW-1:0] m_axis_tdata;
   logic             m_axis_tvalid;
   logic             m_axis_tready;
   logic             m_axis_tuser;
   logic             m_axis_tlast;
   logic             active_sel;
   logic             busy;
   logic             frame_done;
   logic [FCNTW-1:0] frame_cnt;
   logic             err_sof;
   logic             err_nosof;

   always #5 clk = ~clk;

   video_frame_mux #(
      .DATAW(DATAW), .LINES(LINES), .LCNTW(LCNTW), .FCNTW(FCNTW)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .sel(sel),
      .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid),
      .s0_axis_tready(s0_axis_tready), .s0_axis_tuser(s0_axis_tuser),
      .s0_axis_tlast(s0_axis_tlast),
      .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid),
      .s1_axis_tready(s1_axis_tready), .s1_axis_tuser(s1_axis_tuser),
      .s1_axis_tlast(s1_axis_tlast),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser),
      .m_axis_tlast(m_axis_tlast),
      .active_sel(active_sel), .busy(busy), .frame_done(frame_done),
      .frame_cnt(frame_cnt), .err_sof(err_sof), .err_nosof(err_nosof)
   );

   int          checks = 0;
   int          errors = 0;
   logic [25:0] expq[$];
   int          pos0 = 0, frm0 = 0, pos1 = 0, frm1 = 0;
   bit          inj0 = 0, rnd = 0, pend = 0;
   int          fd_n = 0, sof_n = 0, nosof_n = 0, s1_seen = 0;
   logic [25:0] held;

   function automatic logic [23:0] enc(int s, int f, int p);
      return {4'(s), 12'(f), 8'(p)};
   endfunction

   function automatic logic [25:0] exp_beat(int s, int f, int p);
      return {p == 0, (p % 8) == 7, enc(s, f, p)};
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(int s, int f, int first, int last);
      for (int p = first; p <= last; p++) expq.push_back(exp_beat(s, f, p));
   endtask

   task automatic drive();
      if (inj0 && pos0 == 12) begin
         pos0 = 0;
         frm0++;
         inj0 = 0;
      end
      s0_axis_tdata  = enc(0, frm0, pos0);
      s0_axis_tuser  = (pos0 == 0);
      s0_axis_tlast  = (pos0 % 8) == 7;
      s0_axis_tvalid = 1'b1;
      s1_axis_tdata  = enc(1, frm1, pos1);
      s1_axis_tuser  = (pos1 == 0);
      s1_axis_tlast  = (pos1 % 8) == 7;
      s1_axis_tvalid = 1'b1;
      if (rnd) m_axis_tready = 1'($urandom_range(0, 1));
   endtask

   task automatic cycle();
      bit          h0, h1, hm;
      logic [25:0] obs;
      h0  = (s0_axis_tvalid & s0_axis_tready) === 1'b1;
      h1  = (s1_axis_tvalid & s1_axis_tready) === 1'b1;
      hm  = (m_axis_tvalid & m_axis_tready) === 1'b1;
      obs = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
      if (s1_axis_tready === 1'b1) s1_seen++;
      if (pend) begin
         check("stall_hold", {m_axis_tvalid, obs}, {1'b1, held});
         pend = 0;
      end
      if (hm) begin
         if (expq.size() == 0) check("extra_beat", 0, 1);
         else check("beat", obs, expq.pop_front());
      end else if (m_axis_tvalid === 1'b1) begin
         pend = 1;
         held = obs;
      end
      @(posedge clk);
      #1;
      if (h0) begin
         pos0++;
         if (pos0 == 32) begin pos0 = 0; frm0++; end
      end
      if (h1) begin
         pos1++;
         if (pos1 == 32) begin pos1 = 0; frm1++; end
      end
      drive();
      if (frame_done === 1'b1) fd_n++;
      if (err_sof === 1'b1) sof_n++;
      if (err_nosof === 1'b1) nosof_n++;
      #3;
   endtask

   initial begin
      int n;
      int base;
      rst = 1'b1;
      en = 1'b0;
      sel = 1'b0;
      m_axis_tready = 1'b1;
      drive();
      #2;
      cycle();
      cycle();
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tready", {s0_axis_tready, s1_axis_tready}, 0);
      check("rst_busy", busy, 0);
      check("rst_fcnt", frame_cnt, 0);
      check("rst_asel", active_sel, 0);
      rst = 1'b0;
      en = 1'b1;

      // 1: two s0 frames
      s1_seen = 0;
      push(0, 0, 0, 31);
      push(0, 1, 0, 31);
      n = 0;
      while (fd_n < 2 && n < 300) begin cycle(); n++; end
      check("t1_bound", n < 300, 1);
      check("t1_fcnt", frame_cnt, 2);
      check("t1_s1_ready", s1_seen, 0);
      check("t1_q", expq.size(), 0);

      // 2: switch to s1 mid-frame; s1 is mid-frame too
      pos1 = 10;
      base = nosof_n;
      push(0, 2, 0, 31);
      push(1, 1, 0, 31);
      n = 0;
      while (!(frm0 == 2 && pos0 >= 8) && n < 100) begin cycle(); n++; end
      sel = 1'b1;
      while (fd_n < 3 && n < 300) begin cycle(); n++; end
      check("t2_asel", active_sel, 1);
      check("t2_fcnt3", frame_cnt, 3);
      while (fd_n < 4 && n < 400) begin cycle(); n++; end
      check("t2_bound", n < 400, 1);
      check("t2_nosof", nosof_n - base, 22);
      check("t2_q", expq.size(), 0);

      // 3: en drop mid-frame
      push(1, 2, 0, 31);
      n = 0;
      while (!(frm1 == 2 && pos1 >= 5) && n < 100) begin cycle(); n++; end
      en = 1'b0;
      while (fd_n < 5 && n < 200) begin cycle(); n++; end
      check("t3_bound", n < 200, 1);
      for (int i = 0; i < 3; i++) cycle();
      check("t3_tvalid", m_axis_tvalid, 0);
      check("t3_tready", {s0_axis_tready, s1_axis_tready}, 0);
      check("t3_busy", busy, 0);
      check("t3_fcnt", frame_cnt, 5);

      // 4: spurious SOF at beat 12 of an s0 frame
      sel = 1'b0;
      en = 1'b1;
      inj0 = 1;
      base = sof_n;
      push(0, 3, 0, 11);
      push(0, 4, 0, 31);
      n = 0;
      while (fd_n < 6 && n < 200) begin
         if (frm0 == 3 && pos0 >= 3) en = 1'b0;
         cycle();
         n++;
      end
      check("t4_bound", n < 200, 1);
      check("t4_errsof", sof_n - base, 1);
      check("t4_fcnt", frame_cnt, 6);
      check("t4_q", expq.size(), 0);

      // 5: random downstream back-pressure over three frames
      en = 1'b1;
      rnd = 1;
      base = nosof_n;
      push(0, 5, 0, 31);
      push(0, 6, 0, 31);
      push(0, 7, 0, 31);
      n = 0;
      while (fd_n < 9 && n < 2000) begin
         if (frm0 == 7 && pos0 >= 3) en = 1'b0;
         cycle();
         n++;
      end
      rnd = 0;
      m_axis_tready = 1'b1;
      check("t5_bound", n < 2000, 1);
      check("t5_fcnt", frame_cnt, 9);
      check("t5_nosof", nosof_n - base, 0);
      check("t5_q", expq.size(), 0);
      cycle();

      // 6: reset at line 2, then resync on the next SOF
      en = 1'b1;
      push(0, 8, 0, 16);
      n = 0;
      while (pos0 < 16 && n < 100) begin cycle(); n++; end
      check("t6_bound_a", n < 100, 1);
      rst = 1'b1;
      cycle();
      check("t6_tvalid", m_axis_tvalid, 0);
      check("t6_tdata", m_axis_tdata, 0);
      check("t6_tready", {s0_axis_tready, s1_axis_tready}, 0);
      check("t6_flags", {busy, frame_done, err_sof, err_nosof}, 0);
      check("t6_fcnt", frame_cnt, 0);
      rst = 1'b0;
      base = nosof_n;
      push(0, 9, 0, 31);
      n = 0;
      while (frame_cnt !== 16'd1 && n < 200) begin
         if (frm0 == 9 && pos0 >= 3) en = 1'b0;
         cycle();
         n++;
      end
      check("t6_bound_b", n < 200, 1);
      check("t6_nosof", nosof_n - base, 15);
      check("t6_q", expq.size(), 0);
      cycle();
      check("t6_idle", busy, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/video_frame_mux.md
Name: video_frame_mux

Overview:
- Frame-aligned 2:1 AXI4-Stream video selector between two video sources (e.g. video_tpg and a camera/DMA path) and one downstream sink.
- Switches sources, enables and disables only on frame boundaries, so the sink never sees a partial frame.
- Re-synchronises to SOF (tuser) after every frame, counts forwarded frames and flags framing errors.
- Zero-latency combinational forward path; only control state is registered.

Parameters:
DATAW, 24, pixel data width
LINES, 1080, lines per frame; frame end = tlast of line LINES-1
LCNTW, 12, line counter width; must satisfy 2^LCNTW >= LINES
FCNTW, 16, frame counter width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  enable forwarding; sampled each cycle, acted on at frame boundaries
sel  in  1  requested source (0 = s0, 1 = s1)
s0_axis_tdata  in  DATAW  source 0 pixel
s0_axis_tvalid  in  1  source 0 valid
s0_axis_tready  out  1  source 0 ready
s0_axis_tuser  in  1  source 0 SOF
s0_axis_tlast  in  1  source 0 EOL
s1_axis_*  (same five signals, same directions and widths)  source 1
m_axis_tdata  out  DATAW  output pixel
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tuser  out  1  output SOF
m_axis_tlast  out  1  output EOL
active_sel  out  1  source currently owning the output
busy  out  1  high in SYNC or PASS
frame_done  out  1  one-cycle pulse on acceptance of a frame's final beat
frame_cnt  out  FCNTW  completed frames, wraps
err_sof  out  1  one-cycle pulse: tuser seen mid-frame
err_nosof  out  1  one-cycle pulse: non-SOF beat dropped in SYNC

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, active_sel=0, line_cnt=0, frame_cnt=0. All pulses, m_axis_tvalid, busy and both s*_tready are 0. Reset mid-frame abandons the frame immediately; there is no drain.
- Handshakes: beat accepted when valid&ready. Unselected source always sees tready=0 (back-pressured, never dropped).
- IDLE: all tready=0, m_tvalid=0. If en=1: active_sel<=sel, go SYNC next cycle.
- SYNC: selected source S.
  - m_tvalid = S.tvalid & S.tuser.
  - S.tready = S.tuser ? m_tready : 1.
  - Non-SOF valid beat is dropped and pulses err_nosof.
  - Accepted SOF beat is forwarded; line_cnt<=0 (or 1 if that beat also has tlast and LINES>1); go PASS.
- PASS:
  - m_* = S.*; S.tready = m_tready.
  - Each accepted tlast increments line_cnt.
  - Accepted beat with tuser=1 pulses err_sof, restarts the frame (line_cnt<=0 or 1 per its tlast), and is forwarded.
  - Frame end = accepted tlast with line_cnt==LINES-1: frame_done pulse, frame_cnt+1, line_cnt<=0.
  - Next state at frame end: en=0 -> IDLE; en=1 -> SYNC with active_sel<=sel (switch if sel changed).
- en or sel changes mid-frame have no effect until the frame end. en toggling in IDLE/SYNC takes effect the next cycle; SYNC with en=0 -> IDLE.
- Stalls (m_tready=0) hold all counters; source data must stay stable per AXIS.
- frame_cnt wraps 2^FCNTW-1 -> 0.
- LINES=1: every SOF beat's line ends the frame on its tlast.
- Pulses registered: asserted the cycle after the causing handshake.

Test Plan:
(Bench uses LINES=4, 8 px/line, both sources free-running TPG-style, m_tready=1 unless stated.)
1. rst, en=1, sel=0 -> s1_tready stays 0; 2 full frames forwarded from s0 with tuser only on beat 0 and tlast every 8th beat; frame_done twice; frame_cnt=2.
2. sel 0->1 at line 1 of a frame -> s0 frame completes (32 beats); first s1 beat forwarded has tuser=1; active_sel=1 after the boundary; s1 mid-frame beats dropped with err_nosof pulses until its SOF.
3. en=0 mid-frame -> current frame completes; IDLE; m_tvalid=0, both tready=0; busy=0; frame_cnt incremented once.
4. Inject tuser at beat 12 of s0 frame -> err_sof single pulse; line_cnt restarts; frame_done after a further 32 beats.
5. Random m_tready (50%) over 3 frames -> no beat lost or duplicated vs. source sequence; frame_cnt=3; tdata stable while stalled.
6. rst asserted at line 2 -> next cycle all outputs 0, frame_cnt=0; after release with en=1, output resumes at the next SOF only.
